// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg: shared types and constants for the PWM duty meter.
//   state_e     : measurement FSM states (IDLE, HIGH, LOW)
//   duty_e      : 2-bit quantized duty code driven on duty_sel
//   Q_NUM_*     : numerators of the 3/8, 5/8, 7/8 class thresholds
//   GLITCH_HOLD : cycles a new level must persist to count as an edge
//                 (only used when PWM_METER_GLITCH_FILTER_EN is defined)
package pwm_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DUTY_25  = 2'b00,
    DUTY_50  = 2'b01,
    DUTY_75  = 2'b10,
    DUTY_100 = 2'b11
  } duty_e;

  localparam int unsigned Q_NUM_LO  = 3;
  localparam int unsigned Q_NUM_MID = 5;
  localparam int unsigned Q_NUM_HI  = 7;

  localparam int unsigned GLITCH_HOLD = 4;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// pwm_duty_meter_if: bundles the measured pin and the measurement results.
//   pwm_in     : PWM pin under measurement (async to clk)
//   high_cnt   : last high time, clk cycles
//   period_cnt : last period (rise to rise), clk cycles
//   duty_sel   : quantized duty class
//   meas_valid : one-cycle pulse when the results update
//   stuck_high : no edge for 2*NOM cycles while high
//   stuck_low  : no edge for 2*NOM cycles while low
// Modports: master = source of pwm_in / consumer of results,
//           slave  = the meter itself.
interface pwm_duty_meter_if #(
  parameter int unsigned CNT_W = 24
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [1:0]       duty_sel;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  modport master (
    output pwm_in,
    input  high_cnt, period_cnt, duty_sel, meas_valid, stuck_high, stuck_low
  );

  modport slave (
    input  pwm_in,
    output high_cnt, period_cnt, duty_sel, meas_valid, stuck_high, stuck_low
  );
endinterface

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: 2-flop synchronizer for the PWM pin plus rise/fall event
// generation.
//   clk, reset : system clock, synchronous active-high reset
//   i_pwm      : asynchronous PWM input
//   o_rise     : one-cycle rise event
//   o_fall     : one-cycle fall event
// Optional feature macro: PWM_METER_GLITCH_FILTER_EN. When defined, a level
// change is only reported once the synchronized signal has held the new
// level for GLITCH_HOLD consecutive cycles; shorter pulses vanish. Both
// edges see the same extra delay, so measured intervals are unchanged.
module pwm_edge_sync
  import pwm_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_pwm,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_s    <= 1'b0;
    end else begin
      r_meta <= i_pwm;
      r_s    <= r_meta;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  // r_lvl is the accepted level; r_run counts how many cycles before the
  // current one r_s has already disagreed with it.
  logic       r_lvl;
  logic [1:0] r_run;
  logic       w_diff;
  logic       w_take;

  assign w_diff = (r_s != r_lvl);
  // Fires in the 4th consecutive differing cycle: 3 cycles past the
  // unfiltered detection point.
  assign w_take = w_diff && (r_run == 2'(GLITCH_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lvl <= 1'b0;
      r_run <= '0;
    end else if (!w_diff) begin
      r_run <= '0;
    end else if (w_take) begin
      r_lvl <= r_s;
      r_run <= '0;
    end else begin
      r_run <= r_run + 2'd1;
    end
  end

  assign o_rise = w_take &  r_s;
  assign o_fall = w_take & ~r_s;
`else
  logic r_s_d;

  always_ff @(posedge clk) begin
    if (reset) r_s_d <= 1'b0;
    else       r_s_d <= r_s;
  end

  assign o_rise =  r_s & ~r_s_d;
  assign o_fall = ~r_s &  r_s_d;
`endif

endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of a PWM pin, classifies the
// duty into four bins and flags a pin that has stopped toggling.
//   Parameters : CLK_FREQ_HZ, PWM_FREQ_HZ (NOM = CLK/PWM cycles), CNT_W
//   clk        : system clock
//   reset      : synchronous active-high reset
//   bus        : pwm_duty_meter_if.slave (pwm_in in; high_cnt, period_cnt,
//                duty_sel, meas_valid, stuck_high, stuck_low out)
// Optional feature macro: PWM_METER_GLITCH_FILTER_EN (see pwm_edge_sync).
// All outputs are registered. Timeout is 2*NOM cycles without an edge.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned PWM_FREQ_HZ = 50,
  parameter int unsigned CNT_W       = 24
) (
  input  logic                clk,
  input  logic                reset,
  pwm_duty_meter_if.slave     bus
);

  localparam int unsigned     NOM  = CLK_FREQ_HZ / PWM_FREQ_HZ;
  localparam longint unsigned TO_L = 2 * longint'(NOM);
  localparam logic [CNT_W-1:0] TO    = CNT_W'(TO_L);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TO_L - 1);
  localparam int unsigned     QW   = CNT_W + 3;

  // The counter must hold 2*NOM without wrapping.
  if (CNT_W < 40 && (64'd1 << CNT_W) <= TO_L) begin : g_cnt_w_check
    $error("pwm_duty_meter: CNT_W too small for 2*NOM");
  end

  logic w_rise;
  logic w_fall;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_pwm  (bus.pwm_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_e           r_st,     w_st_n;
  logic [CNT_W-1:0] r_cnt,    w_cnt_n;
  logic [CNT_W-1:0] r_hi_tmp, w_hi_tmp_n;
  logic [CNT_W-1:0] r_high,   w_high_n;
  logic [CNT_W-1:0] r_period, w_period_n;
  duty_e            r_duty,   w_duty_n;
  logic             r_mv,     w_mv_n;
  logic             r_sh,     w_sh_n;
  logic             r_sl,     w_sl_n;

  // r_cnt holds (cycles since last rise) - 1, so cnt+1 is the interval that
  // ends on the current edge; the timeout fires after exactly 2*NOM cycles.
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_to;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_to      = (r_cnt == TO_M1);

  // Quantizer on the values being captured at a period-closing rise.
  logic [QW-1:0] w_h8, w_p3, w_p5, w_p7;
  duty_e         w_quant;
  assign w_h8 = {r_hi_tmp, 3'b000};
  assign w_p3 = QW'(w_cnt_inc) * QW'(Q_NUM_LO);
  assign w_p5 = QW'(w_cnt_inc) * QW'(Q_NUM_MID);
  assign w_p7 = QW'(w_cnt_inc) * QW'(Q_NUM_HI);

  always_comb begin
    if      (w_h8 < w_p3) w_quant = DUTY_25;
    else if (w_h8 < w_p5) w_quant = DUTY_50;
    else if (w_h8 < w_p7) w_quant = DUTY_75;
    else                  w_quant = DUTY_100;
  end

  always_comb begin
    w_st_n     = r_st;
    w_cnt_n    = w_to ? r_cnt : w_cnt_inc;  // saturate, never wrap
    w_hi_tmp_n = r_hi_tmp;
    w_high_n   = r_high;
    w_period_n = r_period;
    w_duty_n   = r_duty;
    w_mv_n     = 1'b0;
    w_sh_n     = r_sh;
    w_sl_n     = r_sl;
    // Edges are tested before the timeout so an edge always wins.
    case (r_st)
      IDLE: begin
        if (w_rise) begin
          w_st_n  = HIGH;
          w_cnt_n = '0;
          w_sl_n  = 1'b0;
        end else if (w_to) begin
          w_sl_n  = 1'b1;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_st_n     = LOW;
          w_hi_tmp_n = w_cnt_inc;
          w_sh_n     = 1'b0;
        end else if (w_to && !r_sh) begin
          // Counter stays saturated; r_sh keeps this from re-firing.
          w_sh_n     = 1'b1;
          w_duty_n   = DUTY_100;
          w_high_n   = TO;
          w_period_n = TO;
          w_mv_n     = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_st_n     = HIGH;
          w_period_n = w_cnt_inc;
          w_high_n   = r_hi_tmp;
          w_duty_n   = w_quant;
          w_mv_n     = 1'b1;
          w_cnt_n    = '0;
          w_sl_n     = 1'b0;
        end else if (w_to) begin
          w_st_n = IDLE;
          w_sl_n = 1'b1;
        end
      end
      default: w_st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_hi_tmp <= '0;
      r_high   <= '0;
      r_period <= '0;
      r_duty   <= DUTY_25;
      r_mv     <= 1'b0;
      r_sh     <= 1'b0;
      r_sl     <= 1'b0;
    end else begin
      r_st     <= w_st_n;
      r_cnt    <= w_cnt_n;
      r_hi_tmp <= w_hi_tmp_n;
      r_high   <= w_high_n;
      r_period <= w_period_n;
      r_duty   <= w_duty_n;
      r_mv     <= w_mv_n;
      r_sh     <= w_sh_n;
      r_sl     <= w_sl_n;
    end
  end

  assign bus.high_cnt   = r_high;
  assign bus.period_cnt = r_period;
  assign bus.duty_sel   = r_duty;
  assign bus.meas_valid = r_mv;
  assign bus.stuck_high = r_sh;
  assign bus.stuck_low  = r_sl;

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Measures a PWM waveform on one pin and reports the duty cycle it carries: the high time, the period, a 2-bit duty class, and stuck-high/stuck-low flags. It sits directly downstream of the two-channel PWM generator and closes the loop on `pwm_out_1`/`pwm_out_2`. Its `duty_sel` output is encoded so it can be compared against the generator's selection or fed to the 7-segment driver.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: input clock frequency.
- `PWM_FREQ_HZ`, default 50: nominal PWM frequency. Nominal period `NOM = CLK_FREQ_HZ/PWM_FREQ_HZ`.
- `CNT_W`, default 24: counter width. Must satisfy `2^CNT_W > 2*NOM`; elaboration-time check.
- `clk` input 1: system clock, single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `pwm_in` input 1: PWM to measure. Asynchronous to `clk`; synchronized internally.
- `high_cnt` output CNT_W: last measured high time, in clk cycles.
- `period_cnt` output CNT_W: last measured period, in clk cycles.
- `duty_sel` output 2: quantized duty. 00=25%, 01=50%, 10=75%, 11=100%.
- `meas_valid` output 1: one-cycle pulse when the outputs above update.
- `stuck_high` output 1: no edge for `2*NOM` cycles while the input is high.
- `stuck_low` output 1: no edge for `2*NOM` cycles while the input is low.

## Operation
- `pwm_in` passes through a 2-flop synchronizer, giving signal `s`, then one register `s_d`.
  - Rise event: `s & ~s_d`.
  - Fall event: `~s & s_d`.
- FSM states:
  - IDLE (reset state): wait for a rise.
  - HIGH: counting the high phase.
  - LOW: counting the low phase.
- Transitions:
  - IDLE→HIGH on rise. Clear `cnt`.
  - HIGH→LOW on fall. Latch `hi_tmp = cnt`.
  - LOW→HIGH on rise. Capture `period_cnt = cnt`, `high_cnt = hi_tmp`, update `duty_sel`, pulse `meas_valid`, clear `cnt`.
  - Any state with `cnt == 2*NOM-1`: timeout, described below.
- `cnt` is the cycles elapsed since the last rise, so `period_cnt` equals the distance between consecutive rise events.
- A fall in IDLE is ignored. The first valid measurement needs two rises after reset; a partial period is never reported.
- Quantization is an integer compare on `CNT_W+3` bits, with `h = high_cnt` and `p = period_cnt`:
  - `8h < 3p` → 00.
  - `8h < 5p` → 01.
  - `8h < 7p` → 10.
  - otherwise → 11.
- Timeout in HIGH:
  - Set `stuck_high`, force `duty_sel = 11`, set `high_cnt = period_cnt = 2*NOM`, pulse `meas_valid`.
  - Stay in HIGH with `cnt` frozen (saturated).
  - The next fall clears `stuck_high` and goes to LOW with `hi_tmp` = the saturated value.
- Timeout in LOW or IDLE:
  - Set `stuck_low` and go to IDLE.
  - `duty_sel`, `high_cnt` and `period_cnt` hold. No `meas_valid`.
  - The next rise clears `stuck_low`.
- `cnt` never wraps.
- Reset at any cycle forces the reset values on the next edge. A measurement in progress is discarded.

## Timing
- Reset values: `high_cnt = 0`, `period_cnt = 0`, `duty_sel = 00`, `meas_valid = 0`, `stuck_high = 0`, `stuck_low = 0`, state IDLE, `cnt = 0`.
- All outputs are registered.
- Latency: if clk edge N is the first to sample `pwm_in = 1` on a rise that closes a period, `meas_valid` is high in cycle N+3 for exactly one cycle. Falls have the same pipeline depth.
- The stuck flags assert in the same cycle as the timeout `meas_valid`, or in the equivalent cycle for `stuck_low`.
- Simultaneous timeout and edge in one cycle: the edge wins and the timeout is not taken.

## Configuration
- `PWM_METER_GLITCH_FILTER_EN` defined:
  - An edge is accepted only after `s` holds its new level for 4 consecutive cycles.
  - Shorter pulses are ignored.
  - Latency grows by 3 cycles, to N+6.
  - Measured counts are unaffected, because both edges incur the same delay.
- Undefined: every synchronized transition counts as an edge.

## Structure
- Package `pwm_meter_pkg`:
  - FSM state enum: IDLE, HIGH, LOW.
  - Duty codes: DUTY_25, DUTY_50, DUTY_75, DUTY_100.
  - Quantization numerators 3, 5, 7.
- Sub-module `pwm_edge_sync`: synchronizer, optional glitch filter, rise/fall outputs.
- The top level holds the FSM, counter, capture registers and quantizer.

## Test plan
All scenarios use `CLK_FREQ_HZ = 1000`, `PWM_FREQ_HZ = 10`, so `NOM = 100` and timeout = 200.
- 25 high / 75 low, three periods → `meas_valid` after the 2nd and 3rd rises; `period_cnt = 100`, `high_cnt = 25`, `duty_sel = 00`. Nothing after the 1st rise.
- Duty boundary sweep:
  - high 37 → 00; high 38 → 01.
  - high 62 → 01; high 63 → 10.
  - high 87 → 10; high 88 → 11.
- Constant high for 250 cycles after a rise → at cycle 200, `stuck_high = 1`, `duty_sel = 11`, one `meas_valid`. The following fall clears the flag.
- Constant low for 250 cycles after a 50/50 period → `stuck_low = 1` with no `meas_valid`; `duty_sel = 01` holds. The next rise clears the flag.
- `reset` pulsed during a high phase → all outputs at reset values; the first `meas_valid` comes only after two post-reset rises.
- 2-cycle glitch inside the low phase → with the macro, the 50/50 result is unchanged; without it, a short `period_cnt` is reported.
